// File: rtl/muxn_stream_pkg.sv
// Shared types and constants for the N-channel registered stream multiplexer.
package muxn_stream_pkg;

  typedef enum logic {
    ARB  = 1'b0,
    LOCK = 1'b1
  } state_e;

  localparam logic MODE_SELECT = 1'b0;
  localparam logic MODE_RR     = 1'b1;

endpackage

// File: rtl/muxn_stream_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester at or after ptr,
// wrapping modulo CHANNELS.
module rr_arbiter #(
  parameter  int CHANNELS = 4,
  localparam int SELW     = $clog2(CHANNELS)
) (
  input  logic [CHANNELS-1:0] req,
  input  logic [SELW-1:0]     ptr,
  output logic [SELW-1:0]     grant,
  output logic                grant_valid
);

  // Scan from the farthest offset down to ptr itself so the nearest requester wins.
  always_comb begin
    logic [SELW-1:0] idx;
    grant       = '0;
    grant_valid = 1'b0;
    idx         = '0;
    for (int unsigned k = CHANNELS; k > 0; k--) begin
      idx = SELW'((32'(ptr) + k - 1) % CHANNELS);
      if (req[idx]) begin
        grant       = idx;
        grant_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/muxn_stream.sv
// N-channel, WIDTH-bit registered stream multiplexer with valid/ready handshakes,
// external-select or round-robin arbitration, and packet lock until the last beat.
module muxn_stream
  import muxn_stream_pkg::*;
#(
  parameter  int WIDTH    = 16,
  parameter  int CHANNELS = 4,
  localparam int SELW     = $clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      mode,
  input  logic [SELW-1:0]           sel,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [CHANNELS-1:0]       in_valid,
  input  logic [CHANNELS-1:0]       in_last,
  output logic [CHANNELS-1:0]       in_ready,
  output logic [WIDTH-1:0]          out_data,
  output logic                      out_valid,
  output logic                      out_last,
  output logic [SELW-1:0]           out_chan,
  input  logic                      out_ready
);

  localparam logic [SELW-1:0] LAST_CH = SELW'(CHANNELS - 1);

  state_e            state;
  state_e            state_next;
  logic [SELW-1:0]   ptr;
  logic [SELW-1:0]   lock_ch;
  logic [SELW-1:0]   g;
  logic [SELW-1:0]   arb_grant;
  logic              arb_valid;
  logic              grant_valid;
  logic              load_en;
  logic              xfer;
  logic              g_last;
  logic [WIDTH-1:0]  g_data;

  rr_arbiter #(
    .CHANNELS(CHANNELS)
  ) u_arb (
    .req        (in_valid),
    .ptr        (ptr),
    .grant      (arb_grant),
    .grant_valid(arb_valid)
  );

  assign load_en = !out_valid || out_ready;

  // Pick the candidate channel: locked channel, round-robin winner, or sel.
  // An out-of-range sel matches no channel and therefore never grants.
  always_comb begin
    g           = '0;
    grant_valid = 1'b0;
    if (state == LOCK) begin
      g           = lock_ch;
      grant_valid = in_valid[lock_ch];
    end else if (mode == MODE_RR) begin
      g           = arb_grant;
      grant_valid = arb_valid;
    end else begin
      g = sel;
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        if (SELW'(i) == sel) grant_valid = in_valid[i];
      end
    end
  end

  // Route the granted channel's payload and drive its one-hot ready.
  always_comb begin
    g_data   = '0;
    g_last   = 1'b0;
    in_ready = '0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      if (SELW'(i) == g) begin
        g_data      = in_data[i*WIDTH +: WIDTH];
        g_last      = in_last[i];
        in_ready[i] = !reset && load_en && grant_valid;
      end
    end
  end

  assign xfer = |(in_ready & in_valid);

  // Next-state logic: lock on a non-last beat, release on the last beat.
  always_comb begin
    state_next = state;
    case (state)
      ARB:     if (xfer && !g_last) state_next = LOCK;
      LOCK:    if (xfer && g_last)  state_next = ARB;
      default: state_next = ARB;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= ARB;
    else       state <= state_next;
  end

  // Round-robin pointer advances past a channel only when its last beat moves.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr     <= '0;
      lock_ch <= '0;
    end else if (xfer) begin
      if (g_last) ptr     <= (g == LAST_CH) ? '0 : g + 1'b1;
      else        lock_ch <= g;
    end
  end

  // Output register: load on transfer, drain when the consumer takes the beat.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      out_chan  <= '0;
    end else if (xfer) begin
      out_valid <= 1'b1;
      out_data  <= g_data;
      out_last  <= g_last;
      out_chan  <= g;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_muxn_stream.sv
// Self-checking bench for muxn_stream: directed scenarios then randomized traffic,
// all compared against a transaction-level reference model.
module tb_muxn_stream;

  localparam int W = 16;
  localparam int C = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic         mode;
  logic [1:0]   sel;
  logic [C*W-1:0] in_data;
  logic [C-1:0] in_valid;
  logic [C-1:0] in_last;
  logic [C-1:0] in_ready;
  logic [W-1:0] out_data;
  logic         out_valid;
  logic         out_last;
  logic [1:0]   out_chan;
  logic         out_ready;

  always #5 clk = ~clk;

  muxn_stream #(.WIDTH(W), .CHANNELS(C)) dut (
    .clk(clk), .reset(reset), .mode(mode), .sel(sel),
    .in_data(in_data), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_last(out_last),
    .out_chan(out_chan), .out_ready(out_ready)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state: lock is -1 when not mid-packet.
  int         m_ptr = 0;
  int         m_lock = -1;
  int         m_g = -1;
  int         m_chan = 0;
  logic [W-1:0] m_data = '0;
  logic       m_valid = 1'b0;
  logic       m_last = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int model_grant();
    int c;
    if (reset) return -1;
    if (m_valid && !out_ready) return -1;
    if (m_lock >= 0) return in_valid[m_lock] ? m_lock : -1;
    if (mode) begin
      for (int k = 0; k < C; k++) begin
        c = (m_ptr + k) % C;
        if (in_valid[c]) return c;
      end
      return -1;
    end
    if (int'(sel) < C && in_valid[sel]) return int'(sel);
    return -1;
  endfunction

  task automatic set_data(input int ch, input logic [W-1:0] v);
    in_data[ch*W +: W] = v;
  endtask

  // Before the edge: check the combinational ready against the model's grant.
  task automatic pre();
    logic [C-1:0] exp_rdy;
    #1;
    m_g = model_grant();
    exp_rdy = '0;
    if (m_g >= 0) exp_rdy[m_g] = 1'b1;
    chk("in_ready", 32'(in_ready), 32'(exp_rdy));
  endtask

  // After the edge: advance the model and check the registered outputs.
  task automatic post();
    @(posedge clk);
    #1;
    if (reset) begin
      m_valid = 1'b0; m_data = '0; m_last = 1'b0; m_chan = 0;
      m_ptr = 0; m_lock = -1;
    end else if (m_g >= 0) begin
      m_data  = in_data[m_g*W +: W];
      m_last  = in_last[m_g];
      m_chan  = m_g;
      m_valid = 1'b1;
      if (in_last[m_g]) begin
        m_lock = -1;
        m_ptr  = (m_g + 1) % C;
      end else begin
        m_lock = m_g;
      end
    end else if (out_ready) begin
      m_valid = 1'b0;
    end
    chk("out_valid", 32'(out_valid), 32'(m_valid));
    chk("out_data",  32'(out_data),  32'(m_data));
    chk("out_last",  32'(out_last),  32'(m_last));
    chk("out_chan",  32'(out_chan),  32'(m_chan));
  endtask

  task automatic cycle();
    pre();
    post();
  endtask

  initial begin
    // Reset with every channel requesting.
    reset = 1'b1; mode = 1'b0; sel = 2'd0; in_data = '0;
    in_valid = 4'b1111; in_last = 4'b1111; out_ready = 1'b1;
    pre(); chk("rst_ready", 32'(in_ready), 32'h0); post();
    pre(); chk("rst_ready2", 32'(in_ready), 32'h0); post();
    chk("rst_valid", 32'(out_valid), 32'h0);
    chk("rst_data", 32'(out_data), 32'h0);

    // SELECT mode single beat, then a select pointing at an idle channel.
    reset = 1'b0; mode = 1'b0; sel = 2'd2; set_data(2, 16'h8000);
    in_valid = 4'b0101; in_last = 4'b0100;
    pre(); chk("sel_ready", 32'(in_ready), 32'h4); post();
    chk("sel_data", 32'(out_data), 32'h8000);
    chk("sel_chan", 32'(out_chan), 32'h2);
    sel = 2'd3;
    pre(); chk("sel_idle_ready", 32'(in_ready), 32'h0); post();
    chk("sel_idle_valid", 32'(out_valid), 32'h0);

    // Round-robin fairness from ptr=0 with back-to-back single beats.
    reset = 1'b1; cycle();
    reset = 1'b0; mode = 1'b1; in_valid = 4'b1111; in_last = 4'b1111;
    for (int k = 0; k < C; k++) set_data(k, 16'(k + 1));
    for (int k = 0; k < 6; k++) begin
      cycle();
      chk("rr_chan", 32'(out_chan), 32'(k % C));
      chk("rr_valid", 32'(out_valid), 32'h1);
    end

    // Backpressure holds chan 1 / data 2, then chan 2 follows.
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      pre(); chk("bp_ready", 32'(in_ready), 32'h0); post();
      chk("bp_data", 32'(out_data), 32'h0002);
    end
    out_ready = 1'b1;
    cycle();
    chk("bp_resume_chan", 32'(out_chan), 32'h2);

    // Set ptr=1 via a SELECT beat on ch0, then lock ch1 for a 3-beat packet.
    mode = 1'b0; sel = 2'd0; in_valid = 4'b0001; in_last = 4'b1111;
    cycle();
    mode = 1'b1; in_valid = 4'b0111; in_last = 4'b0000;
    set_data(1, 16'hA001);
    cycle(); chk("lock_b1", 32'(out_chan), 32'h1);
    mode = 1'b0; sel = 2'd2; set_data(1, 16'hA002);
    cycle(); chk("lock_b2", 32'(out_chan), 32'h1);
    in_valid = 4'b0101;
    pre(); chk("lock_stall", 32'(in_ready), 32'h0); post();
    in_valid = 4'b0111; sel = 2'd0; in_last = 4'b0010; set_data(1, 16'hA003);
    cycle(); chk("lock_b3", 32'(out_chan), 32'h1);
    chk("lock_b3_last", 32'(out_last), 32'h1);
    mode = 1'b1; in_last = 4'b0111;
    cycle(); chk("lock_release_rr", 32'(out_chan), 32'h2);

    // Reset while locked on ch3.
    mode = 1'b0; sel = 2'd3; in_valid = 4'b1000; in_last = 4'b0000;
    cycle();
    reset = 1'b1;
    cycle(); chk("midpkt_rst_valid", 32'(out_valid), 32'h0);
    reset = 1'b0; mode = 1'b1; in_valid = 4'b1111; in_last = 4'b1111;
    pre(); chk("post_rst_ready", 32'(in_ready), 32'h1); post();

    // Randomized traffic.
    for (int n = 0; n < 600; n++) begin
      reset     = ($urandom_range(0, 59) == 0);
      mode      = 1'($urandom);
      sel       = 2'($urandom);
      in_valid  = 4'($urandom);
      in_last   = 4'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      for (int k = 0; k < C; k++) set_data(k, 16'($urandom));
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/muxn_stream.md
Name: muxn_stream

Overview:
- Parametrised successor to the 2:1 combinational mux: an N-channel, WIDTH-bit registered stream multiplexer with valid/ready handshakes.
- Two selection modes: external select, or round-robin arbitration.
- Packet lock holds a channel until its last beat has transferred.
- Sits between multiple producers (e.g. register-file/memory read ports) and a single consumer in the datapath.

Parameters:
- WIDTH, 16, data bits per channel.
- CHANNELS, 4, number of input channels (>= 2).
- SELW, $clog2(CHANNELS), select and channel-index width (derived; not overridden).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- mode  input  1  0 = SELECT (use sel), 1 = ROUND_ROBIN.
- sel  input  SELW  channel index used in SELECT mode.
- in_data  input  CHANNELS x WIDTH  per-channel data.
- in_valid  input  CHANNELS  per-channel valid.
- in_last  input  CHANNELS  per-channel end-of-packet flag.
- in_ready  output  CHANNELS  per-channel ready; one-hot or zero.
- out_data  output  WIDTH  registered data.
- out_valid  output  1  registered valid.
- out_last  output  1  registered last flag.
- out_chan  output  SELW  index of the channel that supplied out_data.
- out_ready  input  1  consumer ready.

Behaviour:
- Reset (synchronous, reset=1 at a rising edge):
  - out_valid=0, out_data=0, out_last=0, out_chan=0.
  - ptr=0, state=ARB, lock_ch=0.
  - in_ready is forced to 0 while reset=1.
- Output register:
  - load_en = !out_valid || out_ready.
  - Input beat i transfers when in_valid[i] && in_ready[i].
  - A transfer loads out_data/out_last/out_chan from channel i and sets out_valid=1.
  - If out_ready=1 and no transfer occurs in that cycle, out_valid clears to 0.
  - Latency: 1 cycle from input transfer to out_valid. Full throughput is one beat per cycle while out_ready=1.
  - While out_valid=1 && out_ready=0, all out_* hold and in_ready=0.
- Grant (combinational): in_ready[g] = load_en && grant_valid && (i==g); all other bits 0.
  - State ARB, mode=0: candidate g=sel. grant_valid = (sel < CHANNELS) && in_valid[sel]. An out-of-range sel means no grant.
  - State ARB, mode=1: g = first i with in_valid[i], searching ptr, ptr+1, ..., wrapping modulo CHANNELS. If no channel is valid, there is no grant.
  - State LOCK: g=lock_ch regardless of mode and sel. grant_valid = in_valid[lock_ch].
- State machine (states ARB, LOCK):
  - ARB, transfer with in_last[g]=0 -> LOCK, lock_ch<=g.
  - ARB, transfer with in_last[g]=1 -> stay in ARB.
  - LOCK, transfer with in_last[lock_ch]=1 -> ARB.
  - LOCK, any other cycle -> stay in LOCK.
- Round-robin pointer:
  - Updates only when the channel's last beat transfers (single-beat transfer in ARB, or release from LOCK): ptr <= (g+1) mod CHANNELS.
  - Does not update on non-last beats.
  - Updates in both modes, so a switch to mode=1 continues fairly.
- Mode and sel:
  - Sampled only in ARB.
  - Changes while in LOCK take effect after release.
  - In LOCK, an idle locked channel (in_valid low) stalls the output; no other channel is granted.

Decomposition:
- Package muxn_stream_pkg:
  - state enum {ARB, LOCK}.
  - Mode constants MODE_SELECT=1'b0, MODE_RR=1'b1.
- Sub-module rr_arbiter (combinational, parametrised by CHANNELS):
  - Inputs: request vector and ptr.
  - Outputs: grant index and grant_valid.
- Top level holds the FSM, ptr, lock_ch and the output register.

Test Plan (WIDTH=16, CHANNELS=4):
1. Reset: hold reset=1 for 2 cycles with in_valid=4'b1111 -> in_ready=0, out_valid=0, out_data=16'h0000, out_chan=0.
2. SELECT single beat: mode=0, sel=2, in_data[2]=16'h8000, in_valid=4'b0101, in_last[2]=1, out_ready=1 -> in_ready=4'b0100 in the same cycle; next cycle out_data=16'h8000, out_chan=2, out_valid=1. Then sel=3 with in_valid[3]=0 -> in_ready=0, out_valid drops to 0.
3. RR fairness: mode=1, all channels valid with single-beat data 16'h0001..16'h0004, out_ready=1 -> out_chan sequence 0,1,2,3,0 on consecutive cycles, no bubbles.
4. Backpressure: with out_valid=1 and out_data=16'h0002, hold out_ready=0 for 3 cycles -> out_* held, in_ready=0. Raise out_ready -> the next beat (chan 2) appears one cycle later.
5. Packet lock: mode=1, ptr=1, ch1 sends 3 beats with in_last=0,0,1 while ch0/ch2 are valid; sel toggles and mode flips to 0 mid-packet -> out_chan=1,1,1, then in RR the next grant is ch2 (ptr=2).
6. Reset mid-packet: assert reset during LOCK on ch3 with out_valid=1 -> next cycle out_valid=0, state ARB, ptr=0. After deassert with mode=1 and all valid, the first grant is ch0.
